tcu_ctrl_ext_epfetch: RTL and testbench
=======================================

Name: tcu_ctrl_ext_epfetch

Overview:
Front stage for external EP commands (EXT_INVEP and similar) in tcu_ctrl. Accepts a command, range-checks the EP id and reads the 3 64-bit EP words from the register file. It then presents the assembled 192-bit epdata to the downstream ext command unit with a start pulse. It waits for that unit's done, then returns its error/arg upstream as a one-cycle response.

Parameters:
TCU_REG_ADDR_SIZE, 32, register address width
TCU_REG_DATA_SIZE, 64, register data width
TCU_OPCODE_SIZE, 4, opcode width
TCU_EXT_ARG_SIZE, 64, ext command argument width
TCU_ERROR_SIZE, 5, error code width
TCU_EP_SIZE, 16, EP id width (arg[TCU_EP_SIZE-1:0])
TCU_EP_COUNT, 128, number of implemented EPs
TCU_REGADDR_EP_START, 32'h0000_0040, byte address of EP 0 word 0
TCU_EP_REG_SIZE, 24, bytes per EP (3 words x 8)
TCU_ERROR_NONE, 0, no-error code
TCU_ERROR_INV_EP, 5'h0D, EP id out of range

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE
cmd_opcode_i  in  TCU_OPCODE_SIZE  command opcode
cmd_arg_i  in  TCU_EXT_ARG_SIZE  command argument
resp_valid_o  out  1  one-cycle response pulse
resp_error_o  out  TCU_ERROR_SIZE  response error, valid with resp_valid_o
resp_arg_o  out  TCU_EXT_ARG_SIZE  response argument, valid with resp_valid_o
reg_en_o  out  1  register read request
reg_addr_o  out  TCU_REG_ADDR_SIZE  read address
reg_stall_i  in  1  request not accepted this cycle
reg_rdata_i  in  TCU_REG_DATA_SIZE  read data, valid exactly 1 cycle after accept
ext_start_o  out  1  one-cycle start pulse to ext unit
ext_opcode_o  out  TCU_OPCODE_SIZE  latched opcode
ext_arg_o  out  TCU_EXT_ARG_SIZE  latched argument
ext_epdata_o  out  192  {word2, word1, word0}
ext_done_i  in  1  ext unit finished, one cycle
ext_error_i  in  TCU_ERROR_SIZE  ext unit error, valid with done
ext_arg_i  in  TCU_EXT_ARG_SIZE  ext unit result, valid with done

Behaviour:
- Reset (async, any state): state=IDLE. All registers 0. resp_valid_o=0, ext_start_o=0, reg_en_o=0. resp_error_o=TCU_ERROR_NONE. Outputs 0. cmd_ready_o=1. An in-flight read/ext op is abandoned; late rdata/done are ignored.
- Handshake: a command is taken when cmd_valid_i && cmd_ready_o. Opcode and arg are latched. epid = arg[TCU_EP_SIZE-1:0].
- IDLE -> RESP if epid >= TCU_EP_COUNT: error=TCU_ERROR_INV_EP, arg=0, no register reads.
- IDLE -> READ otherwise. issue_cnt=0, recv_cnt=0.
- READ:
  - reg_en_o=1 while issue_cnt<3.
  - reg_addr_o = TCU_REGADDR_EP_START + epid*TCU_EP_REG_SIZE + issue_cnt*8, truncated to TCU_REG_ADDR_SIZE.
  - Accept = reg_en_o && !reg_stall_i. issue_cnt increments on accept. Address stays stable while stalled.
  - The cycle after each accept, reg_rdata_i is stored into word[recv_cnt] and recv_cnt increments.
  - Pipelined: with no stall, reads issue on 3 consecutive cycles.
  - When recv_cnt reaches 3 (last data captured) -> START.
- START: ext_start_o=1 for exactly one cycle -> WAIT_DONE.
- ext_opcode_o, ext_arg_o and ext_epdata_o are held constant from START until return to IDLE.
- WAIT_DONE: on ext_done_i, latch ext_error_i and ext_arg_i -> RESP. No timeout. A done in the START cycle is ignored.
- RESP: resp_valid_o=1 for one cycle with the latched error/arg -> IDLE.
- Latency, no stalls, immediate done: accept at t0; reads at t1,t2,t3; last data at t4; start at t5; done at t6; resp at t7.
- Invalid-EP latency: resp at t1.
- cmd_ready_o=0 outside IDLE. Back-to-back: the next command can be accepted in the IDLE cycle after RESP.

Test Plan:
- epid=2, no stall, memory words A/B/C: reads at 0x70, 0x78, 0x80 on consecutive cycles -> ext_start_o one pulse, ext_epdata_o={C,B,A}. Done with error 0, arg 0x5 -> resp_valid_o at t7, resp_arg_o=0x5.
- epid=0, reg_stall_i high 3 cycles on word 1: addr 0x48 held stable while stalled, no duplicate capture, epdata correct, start delayed by exactly 3 cycles.
- epid=200 (>=128): no reg_en_o, resp at t1 with error=0x0D, arg=0, ext_start_o never asserted.
- ext_done_i returns error 0x07 after 10 cycles: resp_error_o=0x07. cmd_ready_o stays 0 throughout.
- reset_i asserted during READ after 1 accept: all outputs 0 immediately, cmd_ready_o=1. Stray rdata next cycle is ignored. A new command completes normally.
- Two commands back-to-back with cmd_valid_i held high: the second is accepted the cycle after the first resp_valid_o, and its epdata is independent of the first.

Source files
------------

// File: rtl/tcu_ctrl_ext_epfetch_if.sv
// ---------------------------------------------------------------------------
// tcu_ctrl_ext_epfetch_if
// Bundles the three buses of the external-EP fetch stage:
//   cmd/resp : upstream command request and one-cycle response
//   reg      : register-file read port (en/addr/stall, rdata one cycle later)
//   ext      : downstream ext command unit (start/opcode/arg/epdata, done)
// Modports:
//   slave  - the fetch stage itself
//   master - the environment around it (upstream, register file, ext unit)
// ---------------------------------------------------------------------------
interface tcu_ctrl_ext_epfetch_if #(
    parameter int TCU_REG_ADDR_SIZE = 32,
    parameter int TCU_REG_DATA_SIZE = 64,
    parameter int TCU_OPCODE_SIZE   = 4,
    parameter int TCU_EXT_ARG_SIZE  = 64,
    parameter int TCU_ERROR_SIZE    = 5
);
    logic                           cmd_valid_i;
    logic                           cmd_ready_o;
    logic [TCU_OPCODE_SIZE-1:0]     cmd_opcode_i;
    logic [TCU_EXT_ARG_SIZE-1:0]    cmd_arg_i;
    logic                           resp_valid_o;
    logic [TCU_ERROR_SIZE-1:0]      resp_error_o;
    logic [TCU_EXT_ARG_SIZE-1:0]    resp_arg_o;
    logic                           reg_en_o;
    logic [TCU_REG_ADDR_SIZE-1:0]   reg_addr_o;
    logic                           reg_stall_i;
    logic [TCU_REG_DATA_SIZE-1:0]   reg_rdata_i;
    logic                           ext_start_o;
    logic [TCU_OPCODE_SIZE-1:0]     ext_opcode_o;
    logic [TCU_EXT_ARG_SIZE-1:0]    ext_arg_o;
    logic [3*TCU_REG_DATA_SIZE-1:0] ext_epdata_o;
    logic                           ext_done_i;
    logic [TCU_ERROR_SIZE-1:0]      ext_error_i;
    logic [TCU_EXT_ARG_SIZE-1:0]    ext_arg_i;

    modport slave (
        input  cmd_valid_i, cmd_opcode_i, cmd_arg_i,
        input  reg_stall_i, reg_rdata_i,
        input  ext_done_i, ext_error_i, ext_arg_i,
        output cmd_ready_o, resp_valid_o, resp_error_o, resp_arg_o,
        output reg_en_o, reg_addr_o,
        output ext_start_o, ext_opcode_o, ext_arg_o, ext_epdata_o
    );

    modport master (
        output cmd_valid_i, cmd_opcode_i, cmd_arg_i,
        output reg_stall_i, reg_rdata_i,
        output ext_done_i, ext_error_i, ext_arg_i,
        input  cmd_ready_o, resp_valid_o, resp_error_o, resp_arg_o,
        input  reg_en_o, reg_addr_o,
        input  ext_start_o, ext_opcode_o, ext_arg_o, ext_epdata_o
    );
endinterface

// File: rtl/tcu_ctrl_ext_epfetch.sv
// ---------------------------------------------------------------------------
// tcu_ctrl_ext_epfetch
// Front stage for external EP commands. Takes a command, range-checks the EP
// id, fetches the EP's three 64-bit words from the register file (pipelined,
// stall-aware), starts the ext command unit with the assembled 192-bit
// epdata, waits for its done and returns error/arg upstream for one cycle.
// Ports:
//   clk_i   - clock
//   reset_i - asynchronous active-high reset
//   bus     - cmd/resp, register read and ext unit signals (slave view)
// ---------------------------------------------------------------------------
module tcu_ctrl_ext_epfetch #(
    parameter int                          TCU_REG_ADDR_SIZE    = 32,
    parameter int                          TCU_REG_DATA_SIZE    = 64,
    parameter int                          TCU_OPCODE_SIZE      = 4,
    parameter int                          TCU_EXT_ARG_SIZE     = 64,
    parameter int                          TCU_ERROR_SIZE       = 5,
    parameter int                          TCU_EP_SIZE          = 16,
    parameter int                          TCU_EP_COUNT         = 128,
    parameter logic [31:0]                 TCU_REGADDR_EP_START = 32'h0000_0040,
    parameter int                          TCU_EP_REG_SIZE      = 24,
    parameter logic [TCU_ERROR_SIZE-1:0]   TCU_ERROR_NONE       = '0,
    parameter logic [TCU_ERROR_SIZE-1:0]   TCU_ERROR_INV_EP     = 5'h0D
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    tcu_ctrl_ext_epfetch_if.slave bus
);
    localparam logic [TCU_REG_ADDR_SIZE-1:0] EP_START  = TCU_REG_ADDR_SIZE'(TCU_REGADDR_EP_START);
    localparam logic [TCU_REG_ADDR_SIZE-1:0] EP_STRIDE = TCU_REG_ADDR_SIZE'(TCU_EP_REG_SIZE);
    localparam logic [TCU_EP_SIZE:0]         EP_LIMIT  = (TCU_EP_SIZE+1)'(TCU_EP_COUNT);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_START, S_WAIT_DONE, S_RESP
    } state_t;

    state_t                         state, state_nxt;
    logic [TCU_OPCODE_SIZE-1:0]     opcode_q;
    logic [TCU_EXT_ARG_SIZE-1:0]    arg_q;
    logic [TCU_REG_DATA_SIZE-1:0]   word0_q, word1_q, word2_q;
    logic [1:0]                     issue_cnt, recv_cnt;
    logic                           rd_pend;
    logic [TCU_ERROR_SIZE-1:0]      err_q;
    logic [TCU_EXT_ARG_SIZE-1:0]    rarg_q;

    logic                           take, ep_bad, accept;
    logic                           cmd_ready, resp_valid, ext_start, reg_en;
    logic [TCU_REG_ADDR_SIZE-1:0]   rd_addr, reg_addr;

    assign take   = bus.cmd_valid_i && cmd_ready;
    assign ep_bad = {1'b0, bus.cmd_arg_i[TCU_EP_SIZE-1:0]} >= EP_LIMIT;
    assign accept = reg_en && !bus.reg_stall_i;

    // issue_cnt only moves on accept, so the address holds while stalled
    assign rd_addr = EP_START
                   + TCU_REG_ADDR_SIZE'(arg_q[TCU_EP_SIZE-1:0]) * EP_STRIDE
                   + TCU_REG_ADDR_SIZE'({issue_cnt, 3'b000});

    // state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (take) state_nxt = ep_bad ? S_RESP : S_READ;
            // rd_pend with recv_cnt==2 is the cycle the third word lands
            S_READ:      if (rd_pend && recv_cnt == 2'd2) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.ext_done_i) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        cmd_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
        ext_start  = (state == S_START);
        reg_en     = (state == S_READ) && (issue_cnt != 2'd3);
        reg_addr   = reg_en ? rd_addr : '0;
    end

    // command latch, read counters, word capture and response latch
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            opcode_q  <= '0;
            arg_q     <= '0;
            word0_q   <= '0;
            word1_q   <= '0;
            word2_q   <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_pend   <= 1'b0;
            err_q     <= TCU_ERROR_NONE;
            rarg_q    <= '0;
        end else begin
            if (take) begin
                opcode_q  <= bus.cmd_opcode_i;
                arg_q     <= bus.cmd_arg_i;
                issue_cnt <= '0;
                recv_cnt  <= '0;
                if (ep_bad) begin
                    err_q  <= TCU_ERROR_INV_EP;
                    rarg_q <= '0;
                end
            end
            if (accept) issue_cnt <= issue_cnt + 2'd1;
            // data arrives exactly one cycle after each accept
            rd_pend <= accept;
            if (rd_pend) begin
                case (recv_cnt)
                    2'd0:    word0_q <= bus.reg_rdata_i;
                    2'd1:    word1_q <= bus.reg_rdata_i;
                    default: word2_q <= bus.reg_rdata_i;
                endcase
                recv_cnt <= recv_cnt + 2'd1;
            end
            if (state == S_WAIT_DONE && bus.ext_done_i) begin
                err_q  <= bus.ext_error_i;
                rarg_q <= bus.ext_arg_i;
            end
        end
    end

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_error_o = err_q;
    assign bus.resp_arg_o   = rarg_q;
    assign bus.reg_en_o     = reg_en;
    assign bus.reg_addr_o   = reg_addr;
    assign bus.ext_start_o  = ext_start;
    assign bus.ext_opcode_o = opcode_q;
    assign bus.ext_arg_o    = arg_q;
    assign bus.ext_epdata_o = {word2_q, word1_q, word0_q};
endmodule

// File: tb/tb_tcu_ctrl_ext_epfetch.sv
// ---------------------------------------------------------------------------
// tb_tcu_ctrl_ext_epfetch
// Self-checking bench for tcu_ctrl_ext_epfetch: directed vector table,
// hand-written reset-abort sequence and randomized commands, all checked
// against expectations derived from the EP address map and the command
// timing (fixed read/start/resp latency plus stall and done delays).
// ---------------------------------------------------------------------------
module tb_tcu_ctrl_ext_epfetch;
    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    tcu_ctrl_ext_epfetch_if bus ();
    tcu_ctrl_ext_epfetch dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] arg;
        int          st0, st1, st2;   // stall cycles before each word is accepted
        int          dly;             // extra cycles between start and done
        logic [4:0]  derr;
        logic [63:0] darg;
        bit          stray;           // also pulse done during the start cycle
        bit          keep;            // keep cmd_valid high after the response
        int          exp_lat;         // accept cycle -> resp cycle
        logic [4:0]  exp_err;
        logic [63:0] exp_arg;
    } vec_t;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // register-file content model: distinct word per byte address
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0F0F, ~a};
    endfunction

    function automatic logic [31:0] ep_addr(input int unsigned epid, input int k);
        return 32'h40 + 32'(epid) * 32'd24 + 32'(k) * 32'd8;
    endfunction

    task automatic run_cmd(input vec_t v, input string nm);
        int          stl[3];
        int          n_acc, resp_c, start_c, n_start, n_ready_bad, n_addr_bad, k;
        bit          pend, inval;
        logic [31:0] pend_a;
        int unsigned epid;
        logic [191:0] exp_ep, ep_start, ep_resp;
        logic [3:0]  op_s;
        logic [63:0] arg_s, r_arg;
        logic [4:0]  r_err;

        epid   = 32'(v.arg[15:0]);
        inval  = (epid >= 128);
        exp_ep = {mem_word(ep_addr(epid, 2)), mem_word(ep_addr(epid, 1)), mem_word(ep_addr(epid, 0))};
        stl[0] = v.st0; stl[1] = v.st1; stl[2] = v.st2;
        n_acc = 0; resp_c = -1; start_c = -1; n_start = 0;
        n_ready_bad = 0; n_addr_bad = 0; pend = 1'b0; pend_a = '0;
        ep_start = '0; ep_resp = '0; op_s = '0; arg_s = '0; r_arg = '0; r_err = '0;

        @(negedge clk_i);
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_opcode_i = v.op;
        bus.cmd_arg_i    = v.arg;
        bus.reg_stall_i  = 1'b0;
        bus.ext_done_i   = 1'b0;
        chk({nm, " ready_at_accept"}, 192'(bus.cmd_ready_o), 192'(1));

        for (int c = 1; c <= 400 && resp_c < 0; c++) begin
            @(negedge clk_i);
            if (!v.keep) bus.cmd_valid_i = 1'b0;
            if (bus.cmd_ready_o) n_ready_bad++;
            // return data for last cycle's accept, junk otherwise
            bus.reg_rdata_i = pend ? mem_word(pend_a) : {$urandom, $urandom};
            pend = 1'b0;
            bus.reg_stall_i = 1'b0;
            if (bus.reg_en_o) begin
                k = n_acc;
                if (k > 2 || inval) n_addr_bad++;
                else if (bus.reg_addr_o !== ep_addr(epid, k)) n_addr_bad++;
                if (k < 3 && stl[k] > 0) begin
                    stl[k]--;
                    bus.reg_stall_i = 1'b1;
                end else begin
                    n_acc++;
                    pend   = 1'b1;
                    pend_a = bus.reg_addr_o;
                end
            end
            bus.ext_done_i = 1'b0;
            if (bus.ext_start_o) begin
                n_start++;
                start_c  = c;
                ep_start = bus.ext_epdata_o;
                op_s     = bus.ext_opcode_o;
                arg_s    = bus.ext_arg_o;
                if (v.stray) begin
                    bus.ext_done_i  = 1'b1;
                    bus.ext_error_i = 5'h1F;
                    bus.ext_arg_i   = {$urandom, $urandom};
                end
            end else if (start_c >= 0 && c == start_c + 1 + v.dly) begin
                bus.ext_done_i  = 1'b1;
                bus.ext_error_i = v.derr;
                bus.ext_arg_i   = v.darg;
            end
            if (bus.resp_valid_o) begin
                resp_c  = c;
                r_err   = bus.resp_error_o;
                r_arg   = bus.resp_arg_o;
                ep_resp = bus.ext_epdata_o;
            end
        end
        if (!v.keep) bus.cmd_valid_i = 1'b0;

        chk({nm, " resp_seen"}, 192'(resp_c >= 0), 192'(1));
        chk({nm, " resp_latency"}, 192'(resp_c), 192'(v.exp_lat));
        chk({nm, " resp_error"}, 192'(r_err), 192'(v.exp_err));
        chk({nm, " resp_arg"}, 192'(r_arg), 192'(v.exp_arg));
        chk({nm, " ready_low_busy"}, 192'(n_ready_bad), 192'(0));
        chk({nm, " read_addr_errs"}, 192'(n_addr_bad), 192'(0));
        chk({nm, " reads_accepted"}, 192'(n_acc), 192'(inval ? 0 : 3));
        chk({nm, " start_pulses"}, 192'(n_start), 192'(inval ? 0 : 1));
        if (!inval) begin
            chk({nm, " epdata_start"}, ep_start, exp_ep);
            chk({nm, " epdata_resp"}, ep_resp, exp_ep);
            chk({nm, " ext_opcode"}, 192'(op_s), 192'(v.op));
            chk({nm, " ext_arg"}, 192'(arg_s), 192'(v.arg));
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] arg,
                                input int st0, input int st1, input int st2, input int dly,
                                input logic [4:0] derr, input logic [63:0] darg,
                                input bit stray, input bit keep);
        vec_t v;
        bit   inval;
        inval     = (arg[15:0] >= 16'd128);
        v.op      = op;   v.arg  = arg;
        v.st0     = st0;  v.st1  = st1;  v.st2 = st2;  v.dly = dly;
        v.derr    = derr; v.darg = darg; v.stray = stray; v.keep = keep;
        v.exp_lat = inval ? 1 : 7 + st0 + st1 + st2 + dly;
        v.exp_err = inval ? 5'h0D : derr;
        v.exp_arg = inval ? 64'd0 : darg;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        reset_i          = 1'b1;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_opcode_i = '0;
        bus.cmd_arg_i    = '0;
        bus.reg_stall_i  = 1'b0;
        bus.reg_rdata_i  = '0;
        bus.ext_done_i   = 1'b0;
        bus.ext_error_i  = '0;
        bus.ext_arg_i    = '0;

        // directed vectors; expected fields spelled out for the plan cases
        tbl[0] = '{op:4'h3, arg:64'd2, st0:0, st1:0, st2:0, dly:0, derr:5'h00, darg:64'h5,
                   stray:0, keep:0, exp_lat:7, exp_err:5'h00, exp_arg:64'h5};
        tbl[1] = '{op:4'h5, arg:64'd0, st0:0, st1:3, st2:0, dly:0, derr:5'h00, darg:64'h1234,
                   stray:0, keep:0, exp_lat:10, exp_err:5'h00, exp_arg:64'h1234};
        tbl[2] = '{op:4'h1, arg:64'd200, st0:0, st1:0, st2:0, dly:0, derr:5'h00, darg:64'h77,
                   stray:0, keep:0, exp_lat:1, exp_err:5'h0D, exp_arg:64'h0};
        tbl[3] = '{op:4'h2, arg:64'd7, st0:0, st1:0, st2:0, dly:10, derr:5'h07, darg:64'hABC,
                   stray:0, keep:0, exp_lat:17, exp_err:5'h07, exp_arg:64'hABC};
        tbl[4] = '{op:4'h4, arg:64'd127, st0:0, st1:0, st2:0, dly:2, derr:5'h03, darg:64'd99,
                   stray:1, keep:0, exp_lat:9, exp_err:5'h03, exp_arg:64'd99};
        tbl[5] = '{op:4'h6, arg:64'hFFFF_0000_0000_0080, st0:0, st1:0, st2:0, dly:0, derr:5'h01,
                   darg:64'h1, stray:0, keep:0, exp_lat:1, exp_err:5'h0D, exp_arg:64'h0};
        tbl[6] = '{op:4'h7, arg:64'h0000_1234_0000_0011, st0:1, st1:2, st2:1, dly:1, derr:5'h02,
                   darg:64'hFEED_0000_0000_BEEF, stray:0, keep:0, exp_lat:12, exp_err:5'h02,
                   exp_arg:64'hFEED_0000_0000_BEEF};
        tbl[7] = '{op:4'h8, arg:64'd9, st0:0, st1:0, st2:0, dly:0, derr:5'h00, darg:64'h11,
                   stray:0, keep:1, exp_lat:7, exp_err:5'h00, exp_arg:64'h11};
        tbl[8] = '{op:4'h9, arg:64'd10, st0:0, st1:0, st2:0, dly:0, derr:5'h04, darg:64'h22,
                   stray:0, keep:0, exp_lat:7, exp_err:5'h04, exp_arg:64'h22};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst cmd_ready", 192'(bus.cmd_ready_o), 192'(1));
        chk("rst resp_valid", 192'(bus.resp_valid_o), 192'(0));
        chk("rst ext_start", 192'(bus.ext_start_o), 192'(0));
        chk("rst reg_en", 192'(bus.reg_en_o), 192'(0));
        chk("rst resp_error", 192'(bus.resp_error_o), 192'(0));
        chk("rst epdata", bus.ext_epdata_o, 192'(0));
        reset_i = 1'b0;

        for (int i = 0; i < 9; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // reset while a read is in flight
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_opcode_i = 4'hA;
        bus.cmd_arg_i = 64'd5;
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b0;
        bus.reg_stall_i = 1'b0;
        chk("abort reg_en", 192'(bus.reg_en_o), 192'(1));
        chk("abort addr0", 192'(bus.reg_addr_o), 192'(ep_addr(5, 0)));
        @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("abort async reg_en", 192'(bus.reg_en_o), 192'(0));
        chk("abort async ready", 192'(bus.cmd_ready_o), 192'(1));
        chk("abort async ext_arg", 192'(bus.ext_arg_o), 192'(0));
        chk("abort async reg_addr", 192'(bus.reg_addr_o), 192'(0));
        chk("abort async start", 192'(bus.ext_start_o), 192'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        bus.reg_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk_i);
        chk("abort stray epdata", bus.ext_epdata_o, 192'(0));
        chk("abort idle ready", 192'(bus.cmd_ready_o), 192'(1));
        chk("abort idle reg_en", 192'(bus.reg_en_o), 192'(0));
        run_cmd(tbl[0], "after_abort");

        // randomized commands
        for (int i = 0; i < 40; i++) begin
            int unsigned epid;
            vec_t        v;
            epid = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 65535) : $urandom_range(0, 127);
            v = mk(4'($urandom), {$urandom, 16'($urandom), 16'(epid)},
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                   $urandom_range(0, 4), 5'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            run_cmd(v, $sformatf("rnd%0d", i));
        end
        bus.cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
